csa_tree_pipe: RTL

- Parametrised, pipelined multi-operand carry-save adder tree.
- Reduces NUM_OPS unsigned W-bit operands per transaction through levels of 3:2 compressors, one register stage per level.
- Streaming valid/ready interface with full back-pressure.
- Serves the modular multiplier and accumulation datapaths that need partial-product reduction wider than a single 3:2 stage.

---
 rtl/csa_tree_pipe.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/csa_tree_pipe.sv
// rtl/csa_tree_pipe.sv - pipelined multi-operand 3:2 carry-save adder tree
// Optional final carry-propagate stage enabled by defining CSA_FINAL_CPA_EN.
module csa_tree_pipe #(
  parameter int W = 32,
  parameter int NUM_OPS = 8,
  localparam int OW = W + $clog2(NUM_OPS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_OPS*W-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OW-1:0]          out_c,
  output logic [OW-1:0]          out_s,
  output logic [OW-1:0]          out_sum
);

  function automatic int f_next(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int f_count(input int lvl);
    int n;
    n = NUM_OPS;
    for (int t = 0; t < lvl; t++) n = f_next(n);
    return n;
  endfunction

  function automatic int f_levels(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = f_next(n);
      l++;
    end
    return l;
  endfunction

  localparam int L = f_levels(NUM_OPS);

  logic [OW-1:0] w_src [L][NUM_OPS];
  logic [OW-1:0] w_nxt [L][NUM_OPS];
  logic [OW-1:0] r_stg [L][NUM_OPS];
  logic [L-1:0]  r_vld;
  logic          w_adv;

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  // Bubbles enter as zeros so idle stages never carry stale operands.
  always_comb begin
    for (int i = 0; i < NUM_OPS; i++) begin
      w_src[0][i] = in_valid ? OW'(in_data[i*W +: W]) : '0;
    end
    for (int k = 1; k < L; k++) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        w_src[k][i] = r_stg[k-1][i];
      end
    end
  end

  // Next list order per level: all sums, then all shifted carries, then leftovers.
  always_comb begin
    int n;
    int g;
    n = 0;
    g = 0;
    for (int k = 0; k < L; k++) begin
      n = f_count(k);
      g = n / 3;
      for (int i = 0; i < NUM_OPS; i++) begin
        w_nxt[k][i] = '0;
      end
      for (int j = 0; j < NUM_OPS / 3; j++) begin
        if (j < g) begin
          w_nxt[k][j]   = w_src[k][3*j] ^ w_src[k][3*j+1] ^ w_src[k][3*j+2];
          w_nxt[k][g+j] = ((w_src[k][3*j]   & w_src[k][3*j+1]) |
                           (w_src[k][3*j]   & w_src[k][3*j+2]) |
                           (w_src[k][3*j+1] & w_src[k][3*j+2])) << 1;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (p < n % 3) begin
          w_nxt[k][2*g+p] = w_src[k][3*g+p];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
      for (int k = 0; k < L; k++) begin
        for (int i = 0; i < NUM_OPS; i++) begin
          r_stg[k][i] <= '0;
        end
      end
    end else if (w_adv) begin
      r_vld[0] <= in_valid;
      for (int k = 1; k < L; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
      for (int k = 0; k < L; k++) begin
        for (int i = 0; i < NUM_OPS; i++) begin
          r_stg[k][i] <= w_nxt[k][i];
        end
      end
    end
  end

`ifdef CSA_FINAL_CPA_EN
  logic          r_cpa_vld;
  logic [OW-1:0] r_c;
  logic [OW-1:0] r_s;
  logic [OW-1:0] r_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cpa_vld <= 1'b0;
      r_c       <= '0;
      r_s       <= '0;
      r_sum     <= '0;
    end else if (w_adv) begin
      r_cpa_vld <= r_vld[L-1];
      r_c       <= r_stg[L-1][1];
      r_s       <= r_stg[L-1][0];
      r_sum     <= r_stg[L-1][0] + r_stg[L-1][1];
    end
  end

  assign out_valid = r_cpa_vld;
  assign out_c     = r_c;
  assign out_s     = r_s;
  assign out_sum   = r_sum;
`else
  // The last level always reduces three vectors: sum lands at 0, carry at 1.
  assign out_valid = r_vld[L-1];
  assign out_c     = r_stg[L-1][1];
  assign out_s     = r_stg[L-1][0];
  assign out_sum   = '0;
`endif

endmodule
